// File: rtl/trng_pkg.sv
// Shared types and default constants for the ring-oscillator entropy sampler.
package trng_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    COLLECT,
    STALL
  } trng_state_t;

  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_SAMPLE_DIV    = 16;
  localparam int unsigned DEF_WARMUP_CYCLES = 256;
  localparam int unsigned DEF_OUT_WIDTH     = 8;
  localparam int unsigned DEF_REP_LIMIT     = 32;

  localparam logic [1:0] TAP_LONGEST  = 2'b00;
  localparam logic [1:0] TAP_LONG     = 2'b01;
  localparam logic [1:0] TAP_SHORT    = 2'b10;
  localparam logic [1:0] TAP_SHORTEST = 2'b11;

  // Width of a counter that must hold values 0..n-1 (never less than 1 bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/trng_sampler_vn_debias.sv
// Von Neumann corrector: pairs consecutive raw bits, emits first bit of a (1,0)/(0,1) pair.
module trng_vn_debias (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic in_valid,
  input  logic in_bit,
  output logic out_valid,
  output logic out_bit
);

  logic have_first;
  logic first_bit;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      have_first <= 1'b0;
      first_bit  <= 1'b0;
    end else if (in_valid) begin
      have_first <= !have_first;
      first_bit  <= in_bit;
    end
  end

  // Emission is combinational on the second bit so the packer sees it on the tick cycle.
  assign out_valid = in_valid && have_first && (first_bit != in_bit);
  assign out_bit   = first_bit;

endmodule

// File: rtl/trng_sampler.sv
// Ring-oscillator sampler: sync, divide, debias, pack, valid/ready output.
// Optional repetition-count health test built when TRNG_HEALTH_TEST_EN is defined.
module trng_sampler
  import trng_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned SAMPLE_DIV    = DEF_SAMPLE_DIV,
  parameter int unsigned WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int unsigned OUT_WIDTH     = DEF_OUT_WIDTH,
  parameter int unsigned REP_LIMIT     = DEF_REP_LIMIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           cfg_tap,
  input  logic                 ro_in,
  output logic                 ro_enable,
  output logic [1:0]           ro_feedback_idx,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 health_fail
);

  localparam int unsigned DIV_W = cnt_width(SAMPLE_DIV);
  localparam int unsigned WU_W  = cnt_width(WARMUP_CYCLES);
  localparam int unsigned BIT_W = cnt_width(OUT_WIDTH);

  if (SYNC_STAGES < 2 || SAMPLE_DIV < 2 || OUT_WIDTH < 2 || REP_LIMIT < 2) begin : g_bad_cfg
    $error("trng_sampler: illegal parameter set");
  end

  trng_state_t          state;
  logic [SYNC_STAGES-1:0] sync;
  logic [DIV_W-1:0]     div;
  logic [WU_W-1:0]      wcnt;
  logic [BIT_W-1:0]     bitcnt;
  logic [OUT_WIDTH-1:0] shreg;
  logic [OUT_WIDTH-1:0] word;
  logic                 raw;
  logic                 tick;
  logic                 accept;
  logic                 word_done;
  logic                 vn_clear;
  logic                 vn_valid;
  logic                 vn_bit;
  logic                 rep_trip;

  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], ro_in};
  end

  assign raw       = sync[SYNC_STAGES-1];
  assign tick      = (state == COLLECT) && (div == DIV_W'(SAMPLE_DIV - 1));
  assign accept    = out_valid && out_ready;
  assign word      = {shreg[OUT_WIDTH-2:0], vn_bit};
  assign word_done = vn_valid && (bitcnt == BIT_W'(OUT_WIDTH - 1));
  assign busy      = (state != IDLE);
  assign vn_clear  = (state == IDLE);

  trng_vn_debias u_vn (
    .clk      (clk),
    .rst      (rst),
    .clear    (vn_clear),
    .in_valid (tick),
    .in_bit   (raw),
    .out_valid(vn_valid),
    .out_bit  (vn_bit)
  );

`ifdef TRNG_HEALTH_TEST_EN
  localparam int unsigned REP_W = $clog2(REP_LIMIT + 1);
  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_next;
  logic             prev_raw;

  assign rep_next = (rep_cnt != '0 && raw == prev_raw) ? rep_cnt + 1'b1 : REP_W'(1);
  assign rep_trip = tick && (rep_next == REP_W'(REP_LIMIT));
`else
  assign rep_trip    = 1'b0;
  assign health_fail = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ro_enable       <= 1'b0;
      ro_feedback_idx <= '0;
      out_data        <= '0;
      out_valid       <= 1'b0;
      shreg           <= '0;
      bitcnt          <= '0;
      div             <= '0;
      wcnt            <= '0;
`ifdef TRNG_HEALTH_TEST_EN
      health_fail     <= 1'b0;
      rep_cnt         <= '0;
      prev_raw        <= 1'b0;
`endif
    end else begin
      if (accept) out_valid <= 1'b0;

      // Stop/health-trip takes priority; a word already in out_data survives until accepted.
      if (state != IDLE && (!start || rep_trip)) begin
        state     <= IDLE;
        ro_enable <= 1'b0;
        shreg     <= '0;
        bitcnt    <= '0;
        div       <= '0;
        wcnt      <= '0;
`ifdef TRNG_HEALTH_TEST_EN
        health_fail <= health_fail | rep_trip;
        rep_cnt     <= '0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (start && !health_fail) begin
              state           <= WARMUP;
              ro_enable       <= 1'b1;
              ro_feedback_idx <= cfg_tap;
              wcnt            <= '0;
            end
          end
          WARMUP: begin
            if (wcnt == WU_W'(WARMUP_CYCLES - 1)) begin
              state <= COLLECT;
              div   <= '0;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
          COLLECT: begin
            div <= tick ? '0 : div + 1'b1;
`ifdef TRNG_HEALTH_TEST_EN
            if (tick) begin
              rep_cnt  <= rep_next;
              prev_raw <= raw;
            end
`endif
            if (vn_valid) begin
              if (word_done) begin
                bitcnt <= '0;
                if (!out_valid || out_ready) begin
                  out_data  <= word;
                  out_valid <= 1'b1;
                end else begin
                  shreg <= word;
                  state <= STALL;
                end
              end else begin
                shreg  <= word;
                bitcnt <= bitcnt + 1'b1;
              end
            end
          end
          STALL: begin
            if (accept) begin
              out_data  <= shreg;
              out_valid <= 1'b1;
              state     <= COLLECT;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trng_sampler.sv
// Self-checking bench for trng_sampler with a pair/pack reference model and tick-grid stimulus.
module tb_trng_sampler;
  import trng_pkg::*;

  localparam int unsigned W   = 8;
  localparam int unsigned DIV = 16;
  localparam int unsigned WU  = 256;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   cfg_tap;
  logic         ro_in;
  logic         ro_enable;
  logic [1:0]   ro_feedback_idx;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         health_fail;

  int tests = 0;
  int fails = 0;
  int unsigned cyc = 0;
  int unsigned tick_base = 0;
  int unsigned tick_n = 0;

  logic [W-1:0] got[$];
  logic [W-1:0] exp_q[$];
  bit           stim[$];

  always #5 clk = ~clk;

  trng_sampler #(
    .SYNC_STAGES  (2),
    .SAMPLE_DIV   (DIV),
    .WARMUP_CYCLES(WU),
    .OUT_WIDTH    (W),
    .REP_LIMIT    (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_tap        (cfg_tap),
    .ro_in          (ro_in),
    .ro_enable      (ro_enable),
    .ro_feedback_idx(ro_feedback_idx),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .busy           (busy),
    .health_fail    (health_fail)
  );

  always @(negedge clk) if (!rst && out_valid && out_ready) got.push_back(out_data);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: pair consecutive raw samples, keep first bit of unequal pairs, pack MSB-first.
  function automatic void vn_model(input bit s[$]);
    bit bits[$];
    exp_q.delete();
    for (int i = 0; i + 1 < s.size(); i += 2)
      if (s[i] != s[i+1]) bits.push_back(s[i]);
    for (int k = 0; (k + 1) * W <= bits.size(); k++) begin
      logic [W-1:0] v;
      v = '0;
      for (int j = 0; j < W; j++) v[W-1-j] = bits[k*W + j];
      exp_q.push_back(v);
    end
  endfunction

  function automatic void add_pattern(input int n);
    for (int i = 0; i < n; i++) stim.push_back((i % 4 == 0) || (i % 4 == 3));
  endfunction

  function automatic void add_random_bits(input int nbits);
    int cnt = 0;
    while (cnt < nbits) begin
      bit a, b;
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      stim.push_back(a);
      stim.push_back(b);
      if (a != b) cnt++;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Each sample is held across its tick, which falls every DIV cycles after tick_base.
  task automatic feed(input bit s[$], input bit rnd_ready);
    foreach (s[i]) begin
      int unsigned target;
      ro_in  = s[i];
      target = tick_base + DIV * (tick_n + 1);
      while (cyc < target) begin
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        step();
      end
      tick_n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cfg_tap = 2'b00; ro_in = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    tests++;
    if ({ro_enable, ro_feedback_idx, out_data, out_valid, busy, health_fail} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got en=%b idx=%b data=%h v=%b busy=%b hf=%b expected all 0",
               ro_enable, ro_feedback_idx, out_data, out_valid, busy, health_fail);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_warmup();
    int bad = 0;
    start = 1'b1; cfg_tap = TAP_SHORT;
    step();
    tick_base = cyc + WU; tick_n = 0;
    @(negedge clk);
    tests++;
    if (ro_enable !== 1'b1) begin fails++; $display("FAIL start_enable: got %b expected 1", ro_enable); end
    tests++;
    if (ro_feedback_idx !== 2'b10) begin fails++; $display("FAIL start_tap: got %b expected 10", ro_feedback_idx); end
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL start_busy: got %b expected 1", busy); end
    for (int i = 1; i < int'(WU); i++) begin
      step();
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b1) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL warmup_quiet: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_pattern();
    stim.delete();
    add_pattern(16);
    vn_model(stim);
    feed(stim, 1'b0);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL pattern_valid: got %b expected 1", out_valid); end
    tests++;
    if (out_data !== exp_q[0]) begin fails++; $display("FAIL pattern_data: got %h expected %h", out_data, exp_q[0]); end
  endtask

  task automatic test_const_zero();
    out_ready = 1'b1;
    step();
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL accept_drop: got %b expected 0", out_valid); end
    got.delete();
    stim.delete();
    for (int i = 0; i < 1000; i++) stim.push_back(1'b0);
    feed(stim, 1'b0);
    @(negedge clk);
    tests++;
    if (got.size() != 0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL zero_no_word: got %0d words v=%b expected 0 words", got.size(), out_valid);
    end
    tests++;
    if (health_fail !== 1'b0) begin fails++; $display("FAIL zero_health: got %b expected 0", health_fail); end
  endtask

  task automatic test_back_to_back_stall();
    logic [W-1:0] expw[$];
    int bad = 0;
    out_ready = 1'b0;
    got.delete();
    stim.delete();
    add_pattern(16);
    add_random_bits(W);
    vn_model(stim);
    expw = exp_q;
    feed(stim, 1'b0);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_data !== expw[0] || busy !== 1'b1) begin
      fails++; $display("FAIL stall_first: got v=%b data=%h busy=%b expected v=1 data=%h busy=1",
                        out_valid, out_data, busy, expw[0]);
    end
    for (int i = 0; i < 6; i++) begin
      stim.delete();
      stim.push_back(1'($urandom_range(0, 1)));
      feed(stim, 1'b0);
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== expw[0]) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL stall_hold: got %0d unstable samples expected 0", bad); end
    stim.delete();
    add_random_bits(W);
    vn_model(stim);
    expw.push_back(exp_q[0]);
    out_ready = 1'b1;
    step();
    tick_base = cyc; tick_n = 0;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_data !== expw[1]) begin
      fails++; $display("FAIL stall_second: got v=%b data=%h expected v=1 data=%h", out_valid, out_data, expw[1]);
    end
    feed(stim, 1'b0);
    repeat (3) step();
    tests++;
    if (got.size() != 3) begin fails++; $display("FAIL stall_count: got %0d expected 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      tests++;
      if (got[i] !== expw[i]) begin fails++; $display("FAIL stall_word%0d: got %h expected %h", i, got[i], expw[i]); end
    end
  endtask

  task automatic test_stop_restart();
    logic [1:0] tap;
    out_ready = 1'b0;
    stim.delete();
    add_pattern(6);
    feed(stim, 1'b0);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL stop_pre_valid: got %b expected 0", out_valid); end
    start = 1'b0;
    step();
    @(negedge clk);
    tests++;
    if (ro_enable !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL stop_idle: got en=%b busy=%b expected 0 0", ro_enable, busy);
    end
    tap = 2'($urandom_range(0, 3));
    start = 1'b1; cfg_tap = tap;
    step();
    tick_base = cyc + WU; tick_n = 0;
    @(negedge clk);
    tests++;
    if (ro_enable !== 1'b1 || ro_feedback_idx !== tap) begin
      fails++; $display("FAIL restart_tap: got en=%b idx=%b expected 1 %b", ro_enable, ro_feedback_idx, tap);
    end
    stim.delete();
    add_pattern(16);
    vn_model(stim);
    feed(stim, 1'b0);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
      fails++; $display("FAIL restart_word: got v=%b data=%h expected v=1 data=%h", out_valid, out_data, exp_q[0]);
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_random();
    @(negedge clk);
    got.delete();
    stim.delete();
    for (int i = 0; i < 160; i++) stim.push_back(1'($urandom_range(0, 1)));
    vn_model(stim);
    feed(stim, 1'b1);
    out_ready = 1'b1;
    repeat (4) step();
    tests++;
    if (got.size() != exp_q.size()) begin
      fails++; $display("FAIL random_count: got %0d expected %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      tests++;
      if (got[i] !== exp_q[i]) begin fails++; $display("FAIL random_word%0d: got %h expected %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_mid_reset();
    rst = 1'b1;
    step();
    @(negedge clk);
    tests++;
    if ({ro_enable, ro_feedback_idx, out_data, out_valid, busy, health_fail} !== '0) begin
      fails++; $display("FAIL mid_reset: got en=%b idx=%b data=%h v=%b busy=%b hf=%b expected all 0",
                        ro_enable, ro_feedback_idx, out_data, out_valid, busy, health_fail);
    end
    start = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

`ifdef TRNG_HEALTH_TEST_EN
  task automatic test_health();
    start = 1'b1; cfg_tap = TAP_LONGEST; out_ready = 1'b1;
    step();
    tick_base = cyc + WU; tick_n = 0;
    stim.delete();
    for (int i = 0; i < 31; i++) stim.push_back(1'b1);
    feed(stim, 1'b0);
    @(negedge clk);
    tests++;
    if (health_fail !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL health_early: got hf=%b busy=%b expected 0 1", health_fail, busy);
    end
    stim.delete();
    stim.push_back(1'b1);
    feed(stim, 1'b0);
    @(negedge clk);
    tests++;
    if (health_fail !== 1'b1 || ro_enable !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL health_trip: got hf=%b en=%b busy=%b expected 1 0 0", health_fail, ro_enable, busy);
    end
    repeat (5) step();
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || ro_enable !== 1'b0 || health_fail !== 1'b1) begin
      fails++; $display("FAIL health_sticky: got hf=%b en=%b busy=%b expected 1 0 0", health_fail, ro_enable, busy);
    end
    rst = 1'b1; start = 1'b0;
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    tests++;
    if (health_fail !== 1'b0) begin fails++; $display("FAIL health_clear: got %b expected 0", health_fail); end
  endtask
`endif

  initial begin
    test_reset();
    test_warmup();
    test_pattern();
`ifndef TRNG_HEALTH_TEST_EN
    test_const_zero();
`else
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
`endif
    test_back_to_back_stall();
    test_stop_restart();
    test_random();
    test_mid_reset();
`ifdef TRNG_HEALTH_TEST_EN
    test_health();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
